// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage ALU with valid/ready handshakes on both sides.
//
// Single-cycle logical/arithmetic ops. Shifts with a non-zero amount use an
// iterative shifter that moves SHIFT_STEP bits per cycle, so a shift of n takes
// 1+ceil(n/SHIFT_STEP) cycles. Defining ALU_BARREL_SHIFT_EN swaps in a
// combinational barrel shifter: every op then has latency 1 and busy stays 0.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake (transfer on both high)
//   alu_op                4-bit ALU control code
//   src_a, src_b          operands (shift amount is src_a[4:0], shifted value src_b)
//   ovf_en                1 = trapping add/sub, enables the overflow flag
//   flush                 synchronous kill of in-flight and held work
//   out_valid / out_ready result handshake
//   result, overflow      registered result and signed-overflow flag
//   busy                  iterative shifter in progress
module alu_exec_unit #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ovf_en,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_LUI  = 4'b1010,
    OP_SRL  = 4'b1011,
    OP_SRA  = 4'b1100,
    OP_NOR  = 4'b1101,
    OP_XOR  = 4'b1110
  } alu_op_e;

  typedef enum logic [0:0] {IDLE, SHIFT} state_e;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_kind_e;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        overflow_q, overflow_d;
  logic [31:0] sh_val_q, sh_val_d;
  logic [4:0]  sh_rem_q, sh_rem_d;
  shift_kind_e sh_kind_q, sh_kind_d;

  alu_op_e     op;
  logic [4:0]  shamt;
  logic [31:0] sum, diff;
  logic [31:0] alu_res;
  logic        alu_ovf;
  logic        is_iter;
  shift_kind_e sh_kind;
  logic [4:0]  step_amt;
  logic [31:0] sh_next;
  logic        accept;

  assign op    = alu_op_e'(alu_op);
  assign shamt = src_a[4:0];
  assign sum   = src_a + src_b;
  assign diff  = src_a - src_b;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
`ifdef ALU_BARREL_SHIFT_EN
  assign busy      = 1'b0;
`else
  assign busy      = (state_q == SHIFT);
`endif

  // Single-cycle datapath. In the iterative build a zero-amount shift is just
  // src_b, so only non-zero amounts are sent to the SHIFT state.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    is_iter = 1'b0;
    sh_kind = SH_SLL;
    case (op)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = ovf_en && (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = ovf_en && (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
      end
      OP_SLT:  alu_res = {31'b0, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {31'b0, (src_a < src_b)};
      OP_LUI:  alu_res = {src_b[15:0], 16'h0};
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_XOR:  alu_res = src_a ^ src_b;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = src_b << shamt;
      OP_SRL:  alu_res = src_b >> shamt;
      OP_SRA:  alu_res = $signed(src_b) >>> shamt;
`else
      OP_SLL: begin
        alu_res = src_b;
        is_iter = |shamt;
        sh_kind = SH_SLL;
      end
      OP_SRL: begin
        alu_res = src_b;
        is_iter = |shamt;
        sh_kind = SH_SRL;
      end
      OP_SRA: begin
        alu_res = src_b;
        is_iter = |shamt;
        sh_kind = SH_SRA;
      end
`endif
      default: alu_res = '0;
    endcase
  end

  // One iteration: shift by min(SHIFT_STEP, remaining). An arithmetic shift of
  // the partial value keeps replicating the original bit 31.
  always_comb begin
    step_amt = (sh_rem_q > STEP) ? STEP : sh_rem_q;
    case (sh_kind_q)
      SH_SLL:  sh_next = sh_val_q << step_amt;
      SH_SRL:  sh_next = sh_val_q >> step_amt;
      SH_SRA:  sh_next = $signed(sh_val_q) >>> step_amt;
      default: sh_next = sh_val_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    sh_val_d    = sh_val_q;
    sh_rem_d    = sh_rem_q;
    sh_kind_d   = sh_kind_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
      sh_rem_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_iter) begin
              state_d    = SHIFT;
              sh_val_d   = src_b;
              sh_rem_d   = shamt;
              sh_kind_d  = sh_kind;
              overflow_d = 1'b0;
            end else begin
              result_d    = alu_res;
              overflow_d  = alu_ovf;
              out_valid_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          sh_val_d = sh_next;
          sh_rem_d = sh_rem_q - step_amt;
          if (sh_rem_q == step_amt) begin
            state_d     = IDLE;
            result_d    = sh_next;
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      sh_val_q    <= '0;
      sh_rem_q    <= '0;
      sh_kind_q   <= SH_SLL;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      sh_val_q    <= sh_val_d;
      sh_rem_q    <= sh_rem_d;
      sh_kind_q   <= sh_kind_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_alu_exec_unit;

  localparam int unsigned STEP = 4;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ovf_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Model: output register contents plus the number of cycles the unit is
  // still occupied by a pending shift (0 = free) and that shift's final value.
  logic        m_valid;
  logic [31:0] m_res;
  logic        m_ovf;
  int          m_wait;
  logic [31:0] m_pend;

  alu_exec_unit #(.SHIFT_STEP(STEP)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .ovf_en   (ovf_en),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one op; iters = extra cycles the unit is occupied.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic en, output logic [31:0] r, output logic o,
                                   output int iters);
    longint sa, sb, s;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n = int'(a[4:0]);
    r = '0;
    o = 1'b0;
    iters = 0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = sa + sb;
        r = s[31:0];
        o = en && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        r = s[31:0];
        o = en && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: r = (a < b) ? 32'd1 : 32'd0;
      4'b1001: r = b << n;
      4'b1010: r = {b[15:0], 16'h0};
      4'b1011: r = b >> n;
      4'b1100: begin
        s = sb >>> n;
        r = s[31:0];
      end
      4'b1101: r = ~(a | b);
      4'b1110: r = a ^ b;
      default: r = '0;
    endcase
`ifndef ALU_BARREL_SHIFT_EN
    if ((op == 4'b1001 || op == 4'b1011 || op == 4'b1100) && n > 0)
      iters = (n + int'(STEP) - 1) / int'(STEP);
`endif
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_res   = '0;
    m_ovf   = 1'b0;
    m_wait  = 0;
    m_pend  = '0;
  endtask

  // One clock: compare DUT against the model mid-cycle, advance the model
  // with the inputs of this cycle, return just after the rising edge.
  task automatic step();
    logic exp_rdy, ld, o;
    logic [31:0] r;
    int it;
    @(negedge clk);
    exp_rdy = (m_wait == 0) && (!m_valid || out_ready) && !flush;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_wait != 0);
    if (m_valid) begin
      chk("result", result, m_res);
      chk("overflow", overflow, m_ovf);
    end
    ld = 1'b0;
    if (flush) begin
      m_wait  = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_res = m_pend;
          m_ovf = 1'b0;
          ld    = 1'b1;
        end
      end else if (in_valid && exp_rdy) begin
        model_op(alu_op, src_a, src_b, ovf_en, r, o, it);
        if (it > 0) begin
          m_wait = it;
          m_pend = r;
        end else begin
          m_res = r;
          m_ovf = o;
          ld    = 1'b1;
        end
      end
      if (ld) m_valid = 1'b1;
      else if (m_valid && out_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic en);
    in_valid = v;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    ovf_en   = en;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h7FFF_FFFF;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'($urandom_range(0, 40));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    resetn = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    drive(1'b0, 4'h0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 32'h0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;

    // Signed overflow on add, then the same add non-trapping.
    drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    step();
    chk("add_ovf_res", result, 32'h8000_0000);
    chk("add_ovf_flag", overflow, 1);
    chk("add_ovf_valid", out_valid, 1);
    drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0);
    step();
    chk("addu_res", result, 32'h8000_0000);
    chk("addu_flag", overflow, 0);
    in_valid = 1'b0;
    step();

`ifndef ALU_BARREL_SHIFT_EN
    // sra by 31 with 4-bit steps: 8 busy cycles, result on the 9th.
    drive(1'b1, 4'b1100, 32'd31, 32'h8000_0000, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("sra_busy", busy, 1);
      chk("sra_in_ready", in_ready, 0);
      chk("sra_no_valid", out_valid, 0);
      step();
    end
    chk("sra_valid", out_valid, 1);
    chk("sra_busy_done", busy, 0);
    chk("sra_res", result, 32'hFFFF_FFFF);
    step();
`endif

    // Back-to-back single-cycle ops.
    drive(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    step();
    chk("b2b_and", result, 32'hF000_F000);
    drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'h1, 1'b0);
    step();
    chk("b2b_slt", result, 32'h1);
    drive(1'b1, 4'b1010, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    step();
    chk("b2b_lui", result, 32'h1234_0000);
    chk("b2b_valid", out_valid, 1);
    in_valid = 1'b0;
    step();

    // Backpressure holds the result and blocks issue.
    out_ready = 1'b0;
    drive(1'b1, 4'b1110, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", result, 32'h5A5A_5A5A);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // Flush during a long sll, then a zero-amount sll.
    drive(1'b1, 4'b1001, 32'd20, 32'hFFFF_FFFF, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    drive(1'b1, 4'b1001, 32'd0, 32'h1111_1111, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    drive(1'b1, 4'b1001, 32'd0, 32'h1234_5678, 1'b0);
    step();
    chk("sll0_res", result, 32'h1234_5678);
    chk("sll0_valid", out_valid, 1);
    in_valid = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom));
      out_ready = $urandom_range(0, 9) < 7;
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (10) step();

    // Asynchronous reset in the middle of a shift.
    drive(1'b1, 4'b1001, 32'd31, 32'hCAFE_F00D, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder and returns a registered result.
- Valid/ready handshake on both sides; single-cycle logical/arithmetic ops, iterative multi-cycle shifter (barrel shifter optional).
- Flags signed overflow for add/sub so the pipeline can raise the Ov exception and suppress writeback.

Parameters:
- SHIFT_STEP, 4, bits shifted per iteration cycle; legal values 1, 2, 4, 8, 16.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; transfer on in_valid && in_ready.
- alu_op  in  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1000 sltu, 1001 sll, 1010 lui, 1011 srl, 1100 sra, 1101 nor, 1110 xor.
- src_a  in  32  operand A; shifts use src_a[4:0] as the shift amount.
- src_b  in  32  operand B; the value shifted, and the immediate source for lui.
- ovf_en  in  1  1 = trapping add/sub (add, addi, sub); 0 = addu/addiu/subu.
- flush  in  1  synchronous kill of in-flight and held work.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result on out_valid && out_ready.
- result  out  32  operation result.
- overflow  out  1  signed overflow flag, qualified by out_valid.
- busy  out  1  shifter iterating.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE, out_valid=0, result=0, overflow=0, busy=0, iteration counter=0.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Back-to-back issue gives one result per cycle.
- Non-shift ops, and shifts with amount 0: result registered on the acceptance edge; out_valid=1 the next cycle (latency 1).
- Operation results:
  - add/sub: 32-bit wrap.
  - overflow=1 only if ovf_en=1 and the signed add/sub overflows; result still carries the wrapped value; the consumer suppresses writeback.
  - slt: signed A<B gives 1, else 0. sltu: unsigned compare.
  - lui: {src_b[15:0], 16'h0}.
  - nor: ~(A|B).
  - Opcodes 0011, 0100, 0101, 1111: result=0, overflow=0, latency 1.
- Shifts with amount n>0:
  - Acceptance latches src_b, n and op, and enters SHIFT with busy=1.
  - Each SHIFT cycle shifts by min(SHIFT_STEP, remaining). sra fills with the original bit 31; sll/srl fill with 0.
  - After ceil(n/SHIFT_STEP) cycles: return to IDLE, result loaded, out_valid=1. Total latency 1+ceil(n/SHIFT_STEP).
- Output hold: result and overflow stay stable while out_valid && !out_ready.
- out_valid clears after a handshake unless a new result loads on the same edge.
- flush=1: next edge forces IDLE, out_valid=0, busy=0, overflow=0. Any concurrent in_valid is ignored because in_ready=0.
- resetn asserted mid-SHIFT: immediate return to reset state; partial shift is discarded.
- overflow and slt/sltu results are never 1 when the op does not call for them.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally; every op has latency 1; SHIFT state unused; busy tied to 0; SHIFT_STEP ignored.
- Undefined: iterative shifter as described above.

Test Plan:
- Add with ovf_en=1, A=32'h7FFF_FFFF, B=1, out_ready=1 -> next cycle out_valid=1, result=32'h8000_0000, overflow=1. Same operands with ovf_en=0 -> overflow=0.
- sra, A=31, B=32'h8000_0000, SHIFT_STEP=4 -> busy=1 for 8 cycles; out_valid 9 cycles after acceptance; result=32'hFFFF_FFFF; in_ready=0 throughout.
- Back-to-back and(F0F0_F0F0, FF00_FF00), then slt(-1, 1), then lui(x, 0000_1234), out_ready=1 -> results on consecutive cycles: F000_F000, 1, 1234_0000.
- Backpressure: out_ready=0 for 3 cycles after an xor(A5A5_A5A5, FFFF_FFFF) -> result stays 5A5A_5A5A, in_ready=0; then out_ready=1 -> handshake, in_ready=1.
- flush asserted during an sll of amount 20 -> next cycle busy=0, out_valid=0; a subsequent sll of amount 0 with B=1234_5678 -> result 1234_5678 after 1 cycle.
- resetn pulsed low mid-shift, asynchronously -> out_valid, busy and result read 0 before the next clock edge.
